// File: rtl/vec_alu_pipe_if.sv
// vec_alu_pipe_if: operand-in / result-out handshake bundle for vec_alu_pipe.
// Master drives operands and out_ready; slave (the ALU) drives in_ready and results.
interface vec_alu_pipe_if #(
  parameter int LANES = 16,
  parameter int WIDTH = 32
);
  logic                     in_valid;
  logic                     in_ready;
  logic [1:0]               opcode;
  logic                     acc_clr;
  logic [LANES*WIDTH-1:0]   a;
  logic [LANES*WIDTH-1:0]   b;
  logic                     out_valid;
  logic                     out_ready;
  logic [LANES*2*WIDTH-1:0] result;
  logic [LANES-1:0]         ovf;

  modport master (
    output in_valid, opcode, acc_clr, a, b, out_ready,
    input  in_ready, out_valid, result, ovf
  );

  modport slave (
    input  in_valid, opcode, acc_clr, a, b, out_ready,
    output in_ready, out_valid, result, ovf
  );
endinterface

// File: rtl/vec_alu_pipe.sv
// vec_alu_pipe: 2-stage pipelined SIMD signed ALU (ADD/SUB/MUL/MAC) with
// per-lane accumulators and valid/ready handshakes on both sides.
// Optional saturation: define VEC_ALU_SAT_EN to clamp results (and stored
// accumulators) to the signed WIDTH-bit range and report per-lane ovf.
module vec_alu_pipe #(
  parameter int LANES = 16,
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  vec_alu_pipe_if.slave bus
);
  localparam int RW = 2 * WIDTH;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_MAC = 2'b11
  } op_e;

`ifdef VEC_ALU_SAT_EN
  localparam logic [RW-1:0] SAT_MAX = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [RW-1:0] SAT_MIN = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
`endif

  logic                   stall;
  logic                   advance;

  logic                   s1_valid_q;
  logic [LANES*WIDTH-1:0] s1_a_q;
  logic [LANES*WIDTH-1:0] s1_b_q;
  op_e                    s1_op_q;
  logic                   s1_clr_q;

  logic                   s2_valid_q;
  logic [LANES*RW-1:0]    result_q;
  logic [LANES*RW-1:0]    result_d;
`ifdef VEC_ALU_SAT_EN
  logic [LANES-1:0]       ovf_q;
  logic [LANES-1:0]       ovf_d;
`endif

  logic [RW-1:0]          acc_q [LANES];
  logic [RW-1:0]          acc_d [LANES];

  // Both stages move together; only a held result at S2 freezes the pipe.
  assign stall         = s2_valid_q & ~bus.out_ready;
  assign advance       = ~stall;
  assign bus.in_ready  = advance;
  assign bus.out_valid = s2_valid_q;
  assign bus.result    = result_q;
`ifdef VEC_ALU_SAT_EN
  assign bus.ovf       = ovf_q;
`else
  assign bus.ovf       = '0;
`endif

  // Per-lane arithmetic on the S1 operands, sign-extended to RW bits.
  // Low RW bits of the product of two sign-extended values equal the exact
  // signed product, so an unsigned multiply is sufficient.
  always_comb begin
    logic [RW-1:0] op_a;
    logic [RW-1:0] op_b;
    logic [RW-1:0] prod;
    logic [RW-1:0] acc_base;
    logic [RW-1:0] raw;
    result_d = '0;
`ifdef VEC_ALU_SAT_EN
    ovf_d    = '0;
`endif
    for (int unsigned i = 0; i < LANES; i++) begin
      acc_d[i] = acc_q[i];
      op_a     = {{WIDTH{s1_a_q[i*WIDTH + WIDTH - 1]}}, s1_a_q[i*WIDTH +: WIDTH]};
      op_b     = {{WIDTH{s1_b_q[i*WIDTH + WIDTH - 1]}}, s1_b_q[i*WIDTH +: WIDTH]};
      prod     = op_a * op_b;
      acc_base = s1_clr_q ? '0 : acc_q[i];
      unique case (s1_op_q)
        OP_ADD:  raw = op_a + op_b;
        OP_SUB:  raw = op_a - op_b;
        OP_MUL:  raw = prod;
        OP_MAC:  raw = acc_base + prod;
        default: raw = '0;
      endcase
`ifdef VEC_ALU_SAT_EN
      // In range iff the top WIDTH+1 bits are all copies of the sign bit.
      if (!((&raw[RW-1:WIDTH-1]) || (~|raw[RW-1:WIDTH-1]))) begin
        raw      = raw[RW-1] ? SAT_MIN : SAT_MAX;
        ovf_d[i] = 1'b1;
      end
`endif
      if (s1_op_q == OP_MAC) begin
        acc_d[i] = raw;
      end
      result_d[i*RW +: RW] = raw;
    end
  end

  // S1: capture an accepted beat; bubbles advance as invalid slots.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= OP_ADD;
      s1_clr_q   <= 1'b0;
    end else if (advance) begin
      s1_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        s1_a_q   <= bus.a;
        s1_b_q   <= bus.b;
        s1_op_q  <= op_e'(bus.opcode);
        s1_clr_q <= bus.acc_clr;
      end
    end
  end

  // S2: register the computed beat; held unchanged while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      result_q   <= '0;
`ifdef VEC_ALU_SAT_EN
      ovf_q      <= '0;
`endif
    end else if (advance) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        result_q <= result_d;
`ifdef VEC_ALU_SAT_EN
        ovf_q    <= ovf_d;
`endif
      end
    end
  end

  // Accumulators commit only as a valid beat leaves S1, so a stall cannot add twice.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        acc_q[i] <= '0;
      end
    end else if (advance && s1_valid_q) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        acc_q[i] <= acc_d[i];
      end
    end
  end
endmodule

// File: tb/tb_vec_alu_pipe.sv
// tb_vec_alu_pipe: self-checking bench for vec_alu_pipe (LANES=16, WIDTH=32).
// Honours VEC_ALU_SAT_EN the same way as the design.
module tb_vec_alu_pipe;
  localparam int LANES = 16;
  localparam int WIDTH = 32;
  localparam int RW    = 64;
  localparam longint SMAX = 2147483647;
  localparam longint SMIN = -SMAX - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vec_alu_pipe_if #(.LANES(LANES), .WIDTH(WIDTH)) bus ();
  vec_alu_pipe #(.LANES(LANES), .WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_out    = 0;
  int out_cyc_q[$];

  typedef struct {
    logic [LANES*RW-1:0] res;
    logic [LANES-1:0]    ovf;
  } exp_t;
  exp_t   expq[$];
  longint macc [LANES];

  typedef struct {
    logic [1:0]  op;
    logic        clr;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp_ns;
    logic [63:0] exp_sat;
    logic        ovf_sat;
  } vec_t;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_vec(input string name, input logic [LANES*RW-1:0] act,
                         input logic [LANES*RW-1:0] exp);
    int bad = -1;
    n_checks++;
    for (int i = LANES - 1; i >= 0; i--)
      if (act[i*RW +: RW] !== exp[i*RW +: RW]) bad = i;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s lane %0d: actual=%h required=%h", name, bad,
               act[bad*RW +: RW], exp[bad*RW +: RW]);
    end
  endtask

  function automatic longint clamp(input longint v, output bit o);
    o = 1'b0;
`ifdef VEC_ALU_SAT_EN
    if (v > SMAX) begin v = SMAX; o = 1'b1; end
    else if (v < SMIN) begin v = SMIN; o = 1'b1; end
`endif
    return v;
  endfunction

  // Reference: plain signed 64-bit arithmetic per lane, accumulators as an array.
  function automatic exp_t model_beat(input logic [1:0] op, input logic clr,
                                      input logic [LANES*WIDTH-1:0] av,
                                      input logic [LANES*WIDTH-1:0] bv);
    exp_t e;
    int ta, tb;
    longint sa, sb, r;
    bit o;
    e.res = '0;
    e.ovf = '0;
    for (int i = 0; i < LANES; i++) begin
      ta = av[i*WIDTH +: WIDTH];
      tb = bv[i*WIDTH +: WIDTH];
      sa = ta;
      sb = tb;
      case (op)
        2'd0:    r = sa + sb;
        2'd1:    r = sa - sb;
        2'd2:    r = sa * sb;
        default: r = (clr ? 64'sd0 : macc[i]) + sa * sb;
      endcase
      r = clamp(r, o);
      if (op == 2'd3) macc[i] = r;
      e.res[i*RW +: RW] = r;
      e.ovf[i] = o;
    end
    return e;
  endfunction

  // Scoreboard: record accepted beats, compare consumed beats in order.
  logic                stall_prev = 1'b0;
  logic [LANES*RW-1:0] res_prev;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      expq.delete();
      for (int i = 0; i < LANES; i++) macc[i] = 0;
      stall_prev = 1'b0;
    end else begin
      chk("in_ready", 64'(bus.in_ready), 64'(!(bus.out_valid && !bus.out_ready)));
      if (stall_prev) begin
        chk("hold_valid", 64'(bus.out_valid), 64'd1);
        chk_vec("hold_result", bus.result, res_prev);
      end
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        out_cyc_q.push_back(cyc);
        if (expq.size() == 0) begin
          chk("stale_beat", 64'(bus.out_valid), 64'd0);
        end else begin
          e = expq.pop_front();
          chk_vec("sb_result", bus.result, e.res);
          chk("sb_ovf", 64'(bus.ovf), 64'(e.ovf));
        end
      end
      if (bus.in_valid && bus.in_ready)
        expq.push_back(model_beat(bus.opcode, bus.acc_clr, bus.a, bus.b));
      stall_prev = bus.out_valid && !bus.out_ready;
      res_prev   = bus.result;
    end
  end

  // Call at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [1:0] op, input logic clr,
                      input logic [LANES*WIDTH-1:0] av, input logic [LANES*WIDTH-1:0] bv);
    logic ok;
    int t = 0;
    bus.in_valid = 1'b1;
    bus.opcode   = op;
    bus.acc_clr  = clr;
    bus.a        = av;
    bus.b        = bv;
    do begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      t++;
    end while (!ok && t < 50);
    if (!ok) chk("send_timeout", 64'd0, 64'd1);
    bus.in_valid = 1'b0;
  endtask

  function automatic logic [LANES*WIDTH-1:0] splat(input logic [31:0] v);
    return {LANES{v}};
  endfunction

  function automatic logic [LANES*WIDTH-1:0] rand_vec();
    logic [LANES*WIDTH-1:0] v;
    for (int i = 0; i < LANES; i++)
      v[i*WIDTH +: WIDTH] = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 20)) - 32'd10
                                                         : 32'($urandom);
    return v;
  endfunction

  task automatic drain(input int budget);
    int t = 0;
    while (expq.size() != 0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk("drain_empty", 64'(expq.size()), 64'd0);
  endtask

  vec_t tbl [12];

  initial begin
    logic [63:0]         ev;
    logic [LANES-1:0]    eo;
    logic                ov;
    int                  n0, t;

    tbl[0]  = '{2'd0, 1'b0, 32'h7FFFFFFF, 32'd1, 64'h0000000080000000, 64'h000000007FFFFFFF, 1'b1};
    tbl[1]  = '{2'd1, 1'b0, 32'h80000000, 32'd1, 64'hFFFFFFFF7FFFFFFF, 64'hFFFFFFFF80000000, 1'b1};
    tbl[2]  = '{2'd2, 1'b0, 32'hFFFFFFFD, 32'd7, 64'hFFFFFFFFFFFFFFEB, 64'hFFFFFFFFFFFFFFEB, 1'b0};
    tbl[3]  = '{2'd2, 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF00000001, 64'h000000007FFFFFFF, 1'b1};
    tbl[4]  = '{2'd2, 1'b0, 32'h80000000, 32'h80000000, 64'h4000000000000000, 64'h000000007FFFFFFF, 1'b1};
    tbl[5]  = '{2'd3, 1'b1, 32'd2, 32'd5, 64'd10, 64'd10, 1'b0};
    tbl[6]  = '{2'd3, 1'b0, 32'd2, 32'd5, 64'd20, 64'd20, 1'b0};
    tbl[7]  = '{2'd3, 1'b0, 32'd2, 32'd5, 64'd30, 64'd30, 1'b0};
    tbl[8]  = '{2'd3, 1'b0, 32'd2, 32'd5, 64'd40, 64'd40, 1'b0};
    tbl[9]  = '{2'd0, 1'b1, 32'd1, 32'd1, 64'd2, 64'd2, 1'b0};
    tbl[10] = '{2'd3, 1'b0, 32'd1, 32'd1, 64'd41, 64'd41, 1'b0};
    tbl[11] = '{2'd1, 1'b0, 32'd5, 32'd9, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.opcode    = 2'd0;
    bus.acc_clr   = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk_vec("rst_result", bus.result, '0);
    chk("rst_ovf", 64'(bus.ovf), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Table vectors, one beat at a time with exact latency check.
    for (int k = 0; k < 12; k++) begin
`ifdef VEC_ALU_SAT_EN
      ev = tbl[k].exp_sat;
      eo = tbl[k].ovf_sat ? '1 : '0;
`else
      ev = tbl[k].exp_ns;
      eo = '0;
`endif
      send(tbl[k].op, tbl[k].clr, splat(tbl[k].a), splat(tbl[k].b));
      @(negedge clk);
      chk("lat_early", 64'(bus.out_valid), 64'd0);
      @(negedge clk);
      chk("lat_exact", 64'(bus.out_valid), 64'd1);
      t = 0;
      while (!bus.out_valid && t < 20) begin @(negedge clk); t++; end
      chk_vec($sformatf("tbl%0d_result", k), bus.result, {LANES{ev}});
      chk($sformatf("tbl%0d_ovf", k), 64'(bus.ovf), 64'(eo));
      @(posedge clk);
      #1;
    end

    // Backpressure during a back-to-back MAC stream.
    n0 = n_out;
    fork
      begin
        send(2'd3, 1'b1, splat(32'd2), splat(32'd5));
        for (int k = 0; k < 5; k++) send(2'd3, 1'b0, splat(32'd2), splat(32'd5));
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        repeat (4) begin
          @(negedge clk);
          chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain(30);
    chk("bp_count", 64'(n_out - n0), 64'd6);
    chk("bp_final_acc", bus.result[RW-1:0], 64'd60);
    @(posedge clk);
    #1;

    // Reset with two beats in flight.
    send(2'd2, 1'b0, splat(32'd3), splat(32'd4));
    send(2'd2, 1'b0, splat(32'd5), splat(32'd6));
    ov = bus.out_valid;
    chk("pre_rst_valid", 64'(ov), 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_async_valid", 64'(bus.out_valid), 64'd0);
    chk_vec("rst_async_result", bus.result, '0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n0 = n_out;
    repeat (5) begin
      @(negedge clk);
      chk("no_stale_valid", 64'(bus.out_valid), 64'd0);
    end
    chk("no_stale_count", 64'(n_out - n0), 64'd0);
    @(posedge clk);
    #1;
    send(2'd3, 1'b0, splat(32'd1), splat(32'd1));
    drain(10);
    chk("acc_after_rst", bus.result[RW-1:0], 64'd1);
    @(posedge clk);
    #1;

    // Full throughput: 100 random beats back to back.
    out_cyc_q.delete();
    n0 = n_out;
    for (int k = 0; k < 100; k++)
      send(2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0), rand_vec(), rand_vec());
    drain(20);
    chk("tput_count", 64'(n_out - n0), 64'd100);
    if (out_cyc_q.size() == 100)
      chk("tput_span", 64'(out_cyc_q[99] - out_cyc_q[0]), 64'd99);
    else
      chk("tput_span_size", 64'(out_cyc_q.size()), 64'd100);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
